// File: rtl/sd_host_r2_rx.sv
// sd_host_r2_rx: host-side receiver for the 136-bit SD R2 (CSD) response on CMD
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   bitEn     one-cycle strobe per SD clock rising edge; CMD is sampled only then
//   cmdIn     CMD line level (already synchronised)
//   start     single-cycle arm pulse, ignored while busy
//   busy      high from accepted start until done
//   done      one-cycle completion pulse (success or error)
//   crcErr    CRC7 mismatch, valid with done, held until next start
//   frmErr    framing error, valid with done, held until next start
//   toErr     start-bit timeout, valid with done, held until next start
//   csdR      last good CSD[127:1]
//   readBlLen CSD[83:80], cSize CSD[73:62], cSizeMult CSD[49:47]
module sd_host_r2_rx #(
    parameter int NCR_MAX = 64,
    parameter int CNT_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bitEn,
    input  logic         cmdIn,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         crcErr,
    output logic         frmErr,
    output logic         toErr,
    output logic [126:0] csdR,
    output logic [3:0]   readBlLen,
    output logic [11:0]  cSize,
    output logic [2:0]   cSizeMult
);
    typedef enum logic [2:0] {IDLE, WAIT_START, HEADER, PAYLOAD, END_BIT, DONE} state_t;

    localparam logic [CNT_W-1:0] NCR_LAST = CNT_W'(NCR_MAX - 1);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(6);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(126);
    localparam logic [CNT_W-1:0] CRC_BITS = CNT_W'(120);

    state_t state, next;
    logic [CNT_W-1:0] cnt;
    logic [126:0] sr;
    logic [6:0] crc, crc_next;
    logic frm;
    logic fb;

    // Serial CRC7, polynomial x^7 + x^3 + 1
    assign fb = cmdIn ^ crc[6];
    assign crc_next = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};

    assign busy = (state != IDLE) && (state != DONE);
    assign done = state == DONE;

    // csdR[i] holds CSD[i+1], hence the one-bit offset in these slices
    assign readBlLen = csdR[82:79];
    assign cSize     = csdR[72:61];
    assign cSizeMult = csdR[48:46];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:       next = start ? WAIT_START : IDLE;
            WAIT_START: if (bitEn) next = !cmdIn ? HEADER : (cnt == NCR_LAST ? DONE : WAIT_START);
            HEADER:     next = (bitEn && cnt == HDR_LAST) ? PAYLOAD : HEADER;
            PAYLOAD:    next = (bitEn && cnt == PAY_LAST) ? END_BIT : PAYLOAD;
            END_BIT:    next = bitEn ? DONE : END_BIT;
            default:    next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            sr     <= '0;
            crc    <= '0;
            frm    <= 1'b0;
            crcErr <= 1'b0;
            frmErr <= 1'b0;
            toErr  <= 1'b0;
            csdR   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt    <= '0;
                    crc    <= '0;
                    frm    <= 1'b0;
                    crcErr <= 1'b0;
                    frmErr <= 1'b0;
                    toErr  <= 1'b0;
                end
                WAIT_START: if (bitEn) begin
                    cnt <= cmdIn ? cnt + 1'b1 : '0;
                    if (cmdIn && cnt == NCR_LAST) toErr <= 1'b1;
                end
                // Transmission bit must be 0, the six reserved bits 1; no resync on error
                HEADER: if (bitEn) begin
                    cnt <= cnt == HDR_LAST ? '0 : cnt + 1'b1;
                    if (cmdIn != (cnt != '0)) frm <= 1'b1;
                end
                // Only CSD[127:8] feed the CRC; the trailing 7 bits are the received CRC
                PAYLOAD: if (bitEn) begin
                    cnt <= cnt + 1'b1;
                    sr  <= {sr[125:0], cmdIn};
                    if (cnt < CRC_BITS) crc <= crc_next;
                end
                END_BIT: if (bitEn) begin
                    frmErr <= frm | ~cmdIn;
                    crcErr <= crc != sr[6:0];
                end
                DONE: if (!crcErr && !frmErr && !toErr) csdR <= sr;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_host_r2_rx.sv
// tb_sd_host_r2_rx: directed and randomised frames checked against a behavioural R2 model
module tb_sd_host_r2_rx;
    logic clk = 1'b0, rst = 1'b1, bitEn = 1'b0, cmdIn = 1'b1, start = 1'b0;
    logic busy, done, crcErr, frmErr, toErr;
    logic [126:0] csdR;
    logic [3:0] readBlLen;
    logic [11:0] cSize;
    logic [2:0] cSizeMult;

    sd_host_r2_rx #(.NCR_MAX(64), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bitEn(bitEn), .cmdIn(cmdIn), .start(start),
        .busy(busy), .done(done), .crcErr(crcErr), .frmErr(frmErr), .toErr(toErr),
        .csdR(csdR), .readBlLen(readBlLen), .cSize(cSize), .cSizeMult(cSizeMult)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0, fails = 0;
    int strobes = 0, done_cnt = 0, done_strobe = 0;
    logic [126:0] csd_exp = '0;

    // Strobe counter and done-pulse monitor; done_strobe records how many
    // strobes had occurred when the pulse was seen
    always @(posedge clk) begin
        if (bitEn) strobes <= strobes + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_strobe <= strobes;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division)
    function automatic logic [6:0] crc7_ref(input logic [119:0] d);
        logic [126:0] r;
        r = {d, 7'b0};
        for (int i = 126; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [135:0] mk_frame(input logic [119:0] d);
        return {2'b00, 6'h3f, d, crc7_ref(d), 1'b1};
    endfunction

    function automatic logic [119:0] rnd120();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[119:0];
    endfunction

    // Entered and left at a negedge; a zero gap keeps bitEn high across bits
    task automatic send_bit(input logic b);
        cmdIn = b;
        bitEn = 1'b1;
        @(negedge clk);
        bitEn = 1'b0;
        cmdIn = 1'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_range(input logic [135:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(f[i]);
    endtask

    task automatic arm(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/busy_armed"}, busy, 1);
        chk({tag, "/flags_cleared"}, {crcErr, frmErr, toErr}, 0);
    endtask

    task automatic finish_frame(input string tag, input int s0, input int d0, input int lat,
                                input logic e_crc, input logic e_frm, input logic e_to,
                                input logic [126:0] csd);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "/done_pulses"}, done_cnt - d0, 1);
        chk({tag, "/latency"}, done_strobe - s0, lat);
        chk({tag, "/flags"}, {crcErr, frmErr, toErr}, {e_crc, e_frm, e_to});
        chk({tag, "/idle"}, {busy, done}, 0);
        if (!e_crc && !e_frm && !e_to) csd_exp = csd;
        chk({tag, "/csdR"}, csdR, csd_exp);
        chk({tag, "/readBlLen"}, readBlLen, {csd_exp, 1'b0} >> 80 & 128'hf);
        chk({tag, "/cSize"}, cSize, {csd_exp, 1'b0} >> 62 & 128'hfff);
        chk({tag, "/cSizeMult"}, cSizeMult, {csd_exp, 1'b0} >> 47 & 128'h7);
    endtask

    task automatic run_frame(input string tag, input logic [135:0] f, input int idle,
                             input logic e_crc, input logic e_frm);
        int s0, d0;
        arm(tag);
        repeat (idle) send_bit(1'b1);
        s0 = strobes;
        d0 = done_cnt;
        send_range(f, 135, 0);
        finish_frame(tag, s0, d0, 136, e_crc, e_frm, 1'b0, f[127:1]);
    endtask

    initial begin
        logic [135:0] f;
        logic [119:0] d;
        int s0, d0, k;

        repeat (3) @(negedge clk);
        chk("reset/busy_done", {busy, done}, 0);
        chk("reset/flags", {crcErr, frmErr, toErr}, 0);
        chk("reset/csdR", csdR, 0);
        chk("reset/fields", {readBlLen, cSize, cSizeMult}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame("zero_frame", mk_frame('0), 3, 1'b0, 1'b0);

        for (int n = 0; n < 4; n++) begin
            d = rnd120();
            if (n == 0) d[75:72] = 4'h9;
            run_frame($sformatf("rand_frame%0d", n), mk_frame(d), $urandom_range(0, 10), 1'b0, 1'b0);
        end

        f = mk_frame('0);
        f[1] = 1'b1;
        run_frame("crc_flip", f, 2, 1'b1, 1'b0);

        f = mk_frame(rnd120());
        f[0] = 1'b0;
        run_frame("end_bit0", f, 1, 1'b0, 1'b1);

        f = mk_frame(rnd120());
        f[134] = 1'b1;
        run_frame("tx_bit1", f, 0, 1'b0, 1'b1);

        f = mk_frame(rnd120());
        f[1] = ~f[1];
        f[0] = 1'b0;
        run_frame("crc_and_frm", f, 4, 1'b1, 1'b1);

        arm("timeout");
        s0 = strobes;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            send_bit(1'b1);
            k++;
        end
        finish_frame("timeout", s0, d0, 64, 1'b0, 1'b0, 1'b1, csd_exp);

        run_frame("rearm_good", mk_frame(rnd120()), 5, 1'b0, 1'b0);

        f = mk_frame(rnd120());
        arm("reset_mid");
        send_range(f, 135, 68);
        rst = 1'b1;
        #1;
        chk("reset_mid/busy", busy, 0);
        chk("reset_mid/csdR", csdR, 0);
        csd_exp = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        d = rnd120();
        d[75:72] = 4'h9;
        f = mk_frame(d);
        arm("after_reset");
        send_bit(1'b1);
        s0 = strobes;
        d0 = done_cnt;
        send_range(f, 135, 86);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("after_reset/busy_kept", busy, 1);
        send_range(f, 85, 0);
        finish_frame("after_reset", s0, d0, 136, 1'b0, 1'b0, 1'b0, f[127:1]);
        chk("after_reset/readBlLen9", readBlLen, 9);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sd_host_r2_rx.md
Name: sd_host_r2_rx

Overview:
Host-side receiver for the SD R2 (CSD) response on the CMD line. It is the other end of the slave CSD register and transmitter path. Once armed after CMD9 has been issued, it waits for the start bit and deserialises the 136-bit R2 frame. It checks the frame fields and the internal CRC7, then presents the captured 127-bit CSD and a few decoded capacity fields to the host controller.

Parameters:
NCR_MAX, 64, maximum bit periods from arm to start bit before timeout
CNT_W, 8, width of the internal bit/timeout counter (must hold 136 and NCR_MAX)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
bitEn  input  1  one-cycle strobe per SD clock rising edge; all CMD sampling happens only when bitEn=1
cmdIn  input  1  CMD line level (pre-synchronised)
start  input  1  arm receiver (single-cycle pulse)
busy  output  1  high from accepted start until done
done  output  1  one-cycle completion pulse (success or any error)
crcErr  output  1  CRC7 mismatch, valid with done, held until next start
frmErr  output  1  framing error, valid with done, held until next start
toErr  output  1  start-bit timeout, valid with done, held until next start
csdR  output  127  last good CSD, bits [127:1] of the register
readBlLen  output  4  csdR field READ_BL_LEN (CSD[83:80])
cSize  output  12  csdR field C_SIZE (CSD[73:62])
cSizeMult  output  3  csdR field C_SIZE_MULT (CSD[49:47])

Behaviour:
- Reset (async, rst=1):
  - state IDLE; busy=0, done=0.
  - crcErr=0, frmErr=0, toErr=0.
  - csdR=127'h0, so the decoded fields are 0.
  - A reset mid-frame discards the frame, and csdR is cleared.
- Frame format, MSB first: start 0, transmission 0, reserved 6'b111111, CSD[127:1] (127 bits, CSD[7:1]=CRC7), end bit 1.
- States:
  - IDLE:
    - start=1 -> WAIT_START, busy=1, error flags cleared, counter=0. Arming takes effect the cycle after start.
    - start while busy is ignored.
  - WAIT_START, on bitEn:
    - cmdIn=0 -> HEADER, counter=0.
    - otherwise counter++. When the counter reaches NCR_MAX with no start bit -> DONE with toErr=1.
  - HEADER: 7 bits on bitEn.
    - The first bit must be 0 and the next six must be 1. Any mismatch latches an internal frmErr flag.
    - Reception continues regardless; the machine never resyncs mid-frame.
    - After 7 bits -> PAYLOAD.
  - PAYLOAD: 127 bits shifted into a shift register, MSB first.
    - CRC7 (poly x^7+x^3+1, register initialised to 0) is updated on each of the first 120 bits, i.e. CSD[127:8].
    - The remaining 7 bits are shifted only.
    - After 127 bits -> END.
  - END: on bitEn, sample the end bit; cmdIn=0 latches frmErr. -> DONE.
  - DONE, one clk cycle:
    - done=1, busy=0.
    - crcErr=1 if computed CRC7 != received CSD[7:1].
    - csdR loads from the shift register only if crcErr=0, frmErr=0 and toErr=0; otherwise csdR keeps its previous value.
    - -> IDLE.
- Latency: done asserts in the clk cycle after the bitEn that samples the end bit, which is 136 bitEn strobes after the start bit.
- Decoded fields are combinational slices of csdR, so they change only when csdR loads.
- cmdIn is ignored whenever bitEn=0; bitEn held high continuously is legal.
- Error flags are mutually independent. crcErr and frmErr may both be set in one frame.

Test Plan:
1. Arm, start bit after 3 idle bits, header 0/111111, payload all zeros (CRC7=7'h00), end 1 -> done after 136 strobes from start bit, no errors, csdR=0.
2. Payload CSD[127:8] = random, CRC from bench model, end 1 -> csdR matches payload. Check readBlLen, cSize and cSizeMult against the bit slices, e.g. READ_BL_LEN=4'h9 -> readBlLen=9.
3. Case 1 with CSD[1] flipped to 1 -> crcErr=1, frmErr=0, csdR keeps its prior good value.
4. End bit driven 0, or transmission bit 1 -> frmErr=1, csdR unchanged, done one pulse.
5. Arm with cmdIn held 1 -> toErr=1 and done after exactly NCR_MAX=64 strobes. A re-arm clears toErr.
6. Assert rst at payload bit 60 -> busy=0 and csdR=0 immediately. A subsequent good frame is received correctly. Also check that start pulses during busy are ignored.
